// File: rtl/img_pkg.sv
// rtl/img_pkg.sv - shared CFA, component and FSM constants for the re-mosaic path
//
// Contents:
//   BGGR/GBRG/GRBG/RGGB : 2-bit CFA pattern codes (match debug_cmd[1:0])
//   COMP_R/COMP_G/COMP_B: colour component indices
//   WAIT_SOF/ACTIVE     : line/frame tracker states
//   cfa_comp()          : component kept at a given {row[0], col[0]} parity
package img_pkg;

  localparam logic [1:0] BGGR = 2'b00;
  localparam logic [1:0] GBRG = 2'b01;
  localparam logic [1:0] GRBG = 2'b10;
  localparam logic [1:0] RGGB = 2'b11;

  localparam logic [1:0] COMP_R = 2'd0;
  localparam logic [1:0] COMP_G = 2'd1;
  localparam logic [1:0] COMP_B = 2'd2;

  localparam logic [0:0] WAIT_SOF = 1'b0;
  localparam logic [0:0] ACTIVE   = 1'b1;

  // p = {row parity, col parity}; green is the default on every pattern
  function automatic logic [1:0] cfa_comp(input logic [1:0] cfa, input logic [1:0] p);
    logic [1:0] c;
    c = COMP_G;
    case (cfa)
      BGGR: begin
        if (p == 2'b00) c = COMP_B;
        if (p == 2'b11) c = COMP_R;
      end
      GBRG: begin
        if (p == 2'b01) c = COMP_B;
        if (p == 2'b10) c = COMP_R;
      end
      GRBG: begin
        if (p == 2'b01) c = COMP_R;
        if (p == 2'b10) c = COMP_B;
      end
      default: begin
        if (p == 2'b00) c = COMP_R;
        if (p == 2'b11) c = COMP_B;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rgb2bayer_if.sv
// rtl/rgb2bayer_if.sv - stream bundle used for the RGB input and Bayer output
//
// Signals: tdata[DATA_W], tvalid, tready, tuser (start of frame), tlast (end of line)
// Modports: master drives tdata/tvalid/tuser/tlast; slave drives tready.
interface rgb2bayer_if #(
  parameter int DATA_W = 30
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tuser;
  logic              tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/axis_skid_buf.sv
// rtl/axis_skid_buf.sv - two-entry output stage with a registered ready
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_data/in_valid    : upstream payload and valid
//   in_ready            : registered; low only while the skid entry is occupied
//   out_data/out_valid  : downstream payload and valid (held while stalled)
//   out_ready           : downstream ready
module axis_skid_buf #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] skid_data;
  logic             main_valid;
  logic             skid_valid;
  logic             ready_q;
  logic             in_fire;
  logic             load_main;
  logic             skid_nxt;

  assign in_fire   = in_valid & ready_q;
  // main register may take a new beat when empty or being drained this cycle
  assign load_main = ~main_valid | out_ready;
  // ready_q mirrors an empty skid entry, so a beat can never arrive while it is full
  assign skid_nxt  = load_main ? 1'b0 : (skid_valid | in_fire);

  always_ff @(posedge clk) begin
    if (rst) begin
      main_data  <= '0;
      skid_data  <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      if (load_main) begin
        if (skid_valid) begin
          main_data  <= skid_data;
          main_valid <= 1'b1;
        end else begin
          main_valid <= in_fire;
          if (in_fire) main_data <= in_data;
        end
      end else if (in_fire) begin
        skid_data <= in_data;
      end
      skid_valid <= skid_nxt;
      ready_q    <= ~skid_nxt;
    end
  end

  assign in_ready  = ready_q;
  assign out_data  = main_data;
  assign out_valid = main_valid;

endmodule

// File: rtl/rgb2bayer.sv
// rtl/rgb2bayer.sv - re-mosaics an RGB video stream into a single-component Bayer stream
//
// Ports:
//   pixel_clk, rst : clock, synchronous active-high reset
//   s_axis         : RGB input, tdata = {B, G, R}, tuser = SOF, tlast = EOL
//   m_axis         : Bayer output, tuser/tlast carried from the input beat
//   debug_cmd      : [1:0] CFA pattern, sampled on each SOF beat; [3:2] unused
//   line_err       : one-cycle pulse after a beat that breaks the line length
module rgb2bayer
  import img_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int RGB_WIDTH  = 10,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic         pixel_clk,
  input  logic         rst,
  rgb2bayer_if.slave   s_axis,
  rgb2bayer_if.master  m_axis,
  input  logic [3:0]   debug_cmd,
  output logic         line_err
);

  localparam logic [11:0] LAST_COL = 12'(IMG_WIDTH - 1);
  localparam logic [11:0] LAST_ROW = 12'(IMG_HEIGHT - 1);

  logic [0:0]            state;
  logic [1:0]            bayer_type;
  logic [11:0]           row;
  logic [11:0]           col;

  logic                  in_ready;
  logic                  emit;
  logic                  accept;
  logic [11:0]           eff_row;
  logic [11:0]           eff_col;
  logic [1:0]            eff_type;
  logic [1:0]            comp_sel;
  logic [RGB_WIDTH-1:0]  comp;
  logic [DATA_WIDTH-1:0] sample;
  logic                  line_bad;
  logic                  skid_in_valid;
  logic [DATA_WIDTH+1:0] skid_in;
  logic [DATA_WIDTH+1:0] skid_out;
  logic                  unused_cmd;

  assign unused_cmd = ^debug_cmd[3:2];

  // Before SOF beats are still consumed (ready stays high) but never reach the buffer
  assign emit          = (state == ACTIVE) | s_axis.tuser;
  assign accept        = s_axis.tvalid & in_ready & emit;
  assign skid_in_valid = s_axis.tvalid & emit;

  // A tuser beat is always position (0,0) with a freshly sampled pattern
  assign eff_row  = s_axis.tuser ? 12'd0 : row;
  assign eff_col  = s_axis.tuser ? 12'd0 : col;
  assign eff_type = s_axis.tuser ? debug_cmd[1:0] : bayer_type;
  assign comp_sel = cfa_comp(eff_type, {eff_row[0], eff_col[0]});

  always_comb begin
    comp = s_axis.tdata[3*RGB_WIDTH-1:2*RGB_WIDTH];
    case (comp_sel)
      COMP_R:  comp = s_axis.tdata[RGB_WIDTH-1:0];
      COMP_G:  comp = s_axis.tdata[2*RGB_WIDTH-1:RGB_WIDTH];
      default: ;
    endcase
  end

  generate
    if (DATA_WIDTH > RGB_WIDTH) begin : g_widen
      assign sample = {comp, {(DATA_WIDTH-RGB_WIDTH){1'b0}}};
    end else if (DATA_WIDTH < RGB_WIDTH) begin : g_narrow
      assign sample = comp[RGB_WIDTH-1 -: DATA_WIDTH];
    end else begin : g_pass
      assign sample = comp;
    end
  endgenerate

  // Early tlast, or a missing tlast at the last column
  assign line_bad = s_axis.tlast ? (eff_col != LAST_COL) : (eff_col == LAST_COL);

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state      <= WAIT_SOF;
      bayer_type <= BGGR;
      row        <= '0;
      col        <= '0;
      line_err   <= 1'b0;
    end else begin
      line_err <= accept & line_bad;
      if (accept) begin
        if (s_axis.tuser) bayer_type <= debug_cmd[1:0];
        if (s_axis.tlast) begin
          col   <= '0;
          row   <= eff_row + 12'd1;
          state <= (eff_row == LAST_ROW) ? WAIT_SOF : ACTIVE;
        end else begin
          // col keeps counting past a missing tlast so parity stays consistent
          col   <= eff_col + 12'd1;
          row   <= eff_row;
          state <= ACTIVE;
        end
      end
    end
  end

  assign skid_in = {s_axis.tuser, s_axis.tlast, sample};

  axis_skid_buf #(
    .WIDTH(DATA_WIDTH + 2)
  ) u_skid (
    .clk      (pixel_clk),
    .rst      (rst),
    .in_data  (skid_in),
    .in_valid (skid_in_valid),
    .in_ready (in_ready),
    .out_data (skid_out),
    .out_valid(m_axis.tvalid),
    .out_ready(m_axis.tready)
  );

  assign s_axis.tready = in_ready;
  assign m_axis.tdata  = skid_out[DATA_WIDTH-1:0];
  assign m_axis.tlast  = skid_out[DATA_WIDTH];
  assign m_axis.tuser  = skid_out[DATA_WIDTH+1];

endmodule

// File: tb/tb_rgb2bayer.sv
// tb/tb_rgb2bayer.sv - randomized self-checking bench for rgb2bayer against a frame-level model
module tb_rgb2bayer;

  localparam int DW = 10;
  localparam int RW = 10;
  localparam int IW = 4;
  localparam int IH = 2;

  logic       pixel_clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] debug_cmd = 4'd0;
  logic       line_err;
  bit         bp_on = 1'b0;

  always #5 pixel_clk = ~pixel_clk;

  rgb2bayer_if #(.DATA_W(3*RW)) s_if ();
  rgb2bayer_if #(.DATA_W(DW))   m_if ();

  rgb2bayer #(
    .DATA_WIDTH(DW),
    .RGB_WIDTH (RW),
    .IMG_WIDTH (IW),
    .IMG_HEIGHT(IH)
  ) dut (
    .pixel_clk(pixel_clk),
    .rst      (rst),
    .s_axis   (s_if),
    .m_axis   (m_if),
    .debug_cmd(debug_cmd),
    .line_err (line_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  bit              md_in_frame;
  int              md_row;
  int              md_col;
  int              md_type;
  logic [DW+1:0]   exp_q[$];
  logic [DW+1:0]   obs[$];
  bit              pend_err;
  bit              prev_stall;
  logic [DW+1:0]   prev_out;
  int              mvalid_cycles;

  // R site per pattern; B sits on the diagonally opposite parity, everything else is G
  function automatic logic [RW-1:0] pick(input logic [3*RW-1:0] px, input int cfa,
                                         input int r, input int c);
    int rr, rc;
    case (cfa)
      0: begin rr = 1; rc = 1; end
      1: begin rr = 1; rc = 0; end
      2: begin rr = 0; rc = 1; end
      default: begin rr = 0; rc = 0; end
    endcase
    if ((r % 2) == rr && (c % 2) == rc) return px[RW-1:0];
    if ((r % 2) != rr && (c % 2) != rc) return px[3*RW-1:2*RW];
    return px[2*RW-1:RW];
  endfunction

  task automatic model_step();
    logic [RW-1:0] v;
    if (!md_in_frame && !s_if.tuser) return;
    if (s_if.tuser) begin
      md_row = 0;
      md_col = 0;
      md_type = int'(debug_cmd[1:0]);
      md_in_frame = 1'b1;
    end
    v = pick(s_if.tdata, md_type, md_row, md_col);
    exp_q.push_back({s_if.tuser, s_if.tlast, v});
    pend_err = s_if.tlast ? (md_col != IW - 1) : (md_col == IW - 1);
    if (s_if.tlast) begin
      md_col = 0;
      md_row++;
      if (md_row == IH) md_in_frame = 1'b0;
    end else begin
      md_col = (md_col + 1) % 4096;
    end
  endtask

  // Single compare process: inputs and ready are stable at the falling edge
  always @(negedge pixel_clk) begin
    if (rst) begin
      exp_q.delete();
      md_in_frame = 1'b0;
      pend_err = 1'b0;
      prev_stall = 1'b0;
    end else begin
      check("line_err", line_err, pend_err);
      pend_err = 1'b0;
      if (prev_stall) check("stall_hold", {m_if.tuser, m_if.tlast, m_if.tdata}, prev_out);
      if (m_if.tvalid) mvalid_cycles++;
      if (m_if.tvalid && m_if.tready) begin
        check("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("beat", {m_if.tuser, m_if.tlast, m_if.tdata}, exp_q.pop_front());
        obs.push_back({m_if.tuser, m_if.tlast, m_if.tdata});
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_out = {m_if.tuser, m_if.tlast, m_if.tdata};
      if (s_if.tvalid && s_if.tready) model_step();
    end
  end

  always @(posedge pixel_clk) begin
    #1;
    m_if.tready = bp_on ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge pixel_clk);
      #1;
    end
  endtask

  task automatic send(input logic [RW-1:0] r, input logic [RW-1:0] g, input logic [RW-1:0] b,
                      input bit user, input bit last);
    int budget = 60;
    bit done = 1'b0;
    s_if.tvalid = 1'b1;
    s_if.tdata = {b, g, r};
    s_if.tuser = user;
    s_if.tlast = last;
    while (!done && budget > 0) begin
      @(negedge pixel_clk);
      done = s_if.tready;
      budget--;
      @(posedge pixel_clk);
      #1;
    end
    check("send_accept", done, 1);
    s_if.tvalid = 1'b0;
    s_if.tuser = 1'b0;
    s_if.tlast = 1'b0;
  endtask

  task automatic send_x(input int x, input bit user, input bit last);
    send(10'(100 + x), 10'(200 + x), 10'(300 + x), user, last);
  endtask

  task automatic send_frame(input bit gaps, input bit chg_cmd, input bit rnd);
    for (int y = 0; y < IH; y++) begin
      for (int x = 0; x < IW; x++) begin
        if (rnd) send(10'($urandom), 10'($urandom), 10'($urandom), x == 0 && y == 0, x == IW - 1);
        else     send_x(x, x == 0 && y == 0, x == IW - 1);
        if (chg_cmd && x == 0 && y == 0) debug_cmd = 4'($urandom_range(0, 15));
        if (gaps) idle($urandom_range(0, 2));
      end
    end
  endtask

  task automatic drain();
    int budget = 400;
    while (exp_q.size() != 0 && budget > 0) begin
      idle(1);
      budget--;
    end
    idle(2);
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic check_obs(input string name, input int idx, input int exp_data);
    logic [DW+1:0] e;
    check({name, "_present"}, obs.size() > idx, 1);
    if (obs.size() > idx) begin
      e = obs[idx];
      check(name, e[DW-1:0], exp_data);
    end
  endtask

  // ---------------- test sequence ----------------
  int basic_lit[8] = '{300, 201, 302, 203, 200, 101, 202, 103};
  int cfa_lit0[4]  = '{300, 200, 200, 100};
  int cfa_lit1[4]  = '{201, 301, 101, 201};
  logic [DW+1:0] ent;

  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tuser  = 1'b0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;

    // reset state
    repeat (3) @(posedge pixel_clk);
    #1;
    check("rst_m_tvalid", m_if.tvalid, 0);
    check("rst_m_tdata", m_if.tdata, 0);
    check("rst_m_tuser", m_if.tuser, 0);
    check("rst_m_tlast", m_if.tlast, 0);
    check("rst_line_err", line_err, 0);
    check("rst_s_tready", s_if.tready, 0);
    rst = 1'b0;
    idle(1);
    check("ready_after_reset", s_if.tready, 1);

    // pre-SOF beats are dropped
    mvalid_cycles = 0;
    for (int i = 0; i < 5; i++) send_x(i, 1'b0, 1'b0);
    idle(2);
    check("pre_sof_no_output", mvalid_cycles, 0);

    // basic BGGR frame with latency check on the first beat
    debug_cmd = 4'd0;
    obs.delete();
    send_x(0, 1'b1, 1'b0);
    check("latency_valid", m_if.tvalid, 1);
    check("latency_data", m_if.tdata, 300);
    check("latency_tuser", m_if.tuser, 1);
    for (int i = 1; i < 8; i++) send_x(i % IW, 1'b0, (i % IW) == IW - 1);
    drain();
    for (int i = 0; i < 8; i++) check_obs("basic_px", i, basic_lit[i]);
    if (obs.size() == 8) begin
      ent = obs[3];
      check("basic_tlast3", ent[DW], 1);
      ent = obs[7];
      check("basic_tlast7", ent[DW], 1);
    end

    // other CFA types; debug_cmd changes after SOF must not matter
    for (int t = 1; t < 4; t++) begin
      debug_cmd = 4'(t);
      obs.delete();
      send_x(0, 1'b1, 1'b0);
      debug_cmd = 4'((t + 1) % 4);
      for (int i = 1; i < 8; i++) send_x(i % IW, 1'b0, (i % IW) == IW - 1);
      drain();
      check_obs("cfa_px0", 0, cfa_lit0[t]);
      check_obs("cfa_px1", 1, cfa_lit1[t]);
    end

    // backpressure over three frames
    bp_on = 1'b1;
    for (int f = 0; f < 3; f++) begin
      debug_cmd = 4'($urandom_range(0, 15));
      send_frame(1'b1, 1'b1, 1'b1);
    end
    drain();
    bp_on = 1'b0;
    idle(2);

    // line-length errors
    debug_cmd = 4'd0;
    obs.delete();
    send_x(0, 1'b1, 1'b0);
    send_x(1, 1'b0, 1'b0);
    send_x(2, 1'b0, 1'b1);
    check("early_tlast_err", line_err, 1);
    idle(1);
    check("err_one_cycle", line_err, 0);
    for (int x = 0; x < 5; x++) begin
      send_x(x, 1'b0, x == 4);
      if (x == 3) check("missing_tlast_err", line_err, 1);
    end
    drain();
    check_obs("wrap_parity_px", 7, 204);

    // reset mid-line, then a fresh frame is required
    send_x(0, 1'b1, 1'b0);
    send_x(1, 1'b0, 1'b0);
    rst = 1'b1;
    idle(1);
    check("midrst_m_tvalid", m_if.tvalid, 0);
    check("midrst_m_tdata", m_if.tdata, 0);
    check("midrst_line_err", line_err, 0);
    check("midrst_s_tready", s_if.tready, 0);
    rst = 1'b0;
    idle(1);
    mvalid_cycles = 0;
    send_x(2, 1'b0, 1'b0);
    send_x(3, 1'b0, 1'b1);
    idle(2);
    check("post_rst_drop", mvalid_cycles, 0);
    send_frame(1'b0, 1'b0, 1'b0);
    drain();

    // mid-frame resync with a new pattern
    debug_cmd = 4'd0;
    obs.delete();
    send_x(0, 1'b1, 1'b0);
    send_x(1, 1'b0, 1'b0);
    debug_cmd = 4'd3;
    send_x(0, 1'b1, 1'b0);
    for (int i = 1; i < 8; i++) send_x(i % IW, 1'b0, (i % IW) == IW - 1);
    drain();
    check_obs("resync_px", 2, 100);

    // tuser and tlast on the same beat
    debug_cmd = 4'd0;
    obs.delete();
    send_x(0, 1'b1, 1'b1);
    for (int x = 0; x < IW; x++) send_x(x, 1'b0, x == IW - 1);
    drain();
    check_obs("sof_eol_px0", 0, 300);
    check_obs("sof_eol_px1", 1, 200);

    // random beats: random SOF/EOL insertion, gaps, backpressure and pattern
    bp_on = 1'b1;
    for (int i = 0; i < 150; i++) begin
      debug_cmd = 4'($urandom_range(0, 15));
      send(10'($urandom), 10'($urandom), 10'($urandom),
           (i == 0) || ($urandom_range(0, 19) == 0), $urandom_range(0, 4) == 0);
      idle($urandom_range(0, 1));
    end
    drain();
    bp_on = 1'b0;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
